cache_ctrl: RTL and testbench

//  Sequencer for the direct-mapped write-back cache datapath (data RAM, tag RAM).

---
 rtl/cache_ctrl_pkg.sv | 24 ++
 rtl/cache_ctrl_bus_seq.sv | 39 +++
 rtl/cache_ctrl.sv | 154 +++++++++++++++
 tb/tb_cache_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared state encoding, line geometry and byte-lane merge helper for cache_ctrl
package cache_ctrl_pkg;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, WB, RF, FILL, UNC} cacheState;

    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int LINE_OFS = 4;

    // Tag RAM rows are laid out as {valid, dirty, tag}.
    function automatic logic [LINE_W-1:0] mergeWord(
        input logic [LINE_W-1:0] line,
        input logic [1:0]        word,
        input logic [3:0]        be,
        input logic [WORD_W-1:0] data
    );
        logic [LINE_W-1:0] merged;
        merged = line;
        for (int b = 0; b < 4; b++)
            if (be[b]) merged[{word, 5'd0} + 8*b +: 8] = data[8*b +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/cache_ctrl_bus_seq.sv
// cache_ctrl_bus_seq: m0 word sequencer for 4-beat line transfers or a single uncached beat
module cache_ctrl_bus_seq (
    input  logic       clk,
    input  logic       rest,
    input  logic       run,
    input  logic       isWrite,
    input  logic       single,
    input  logic       m0_waitRequest,
    input  logic       m0_readDataValid,
    output logic [1:0] beat,
    output logic       m0_read,
    output logic       m0_write,
    output logic       capture,
    output logic       done
);

    logic pending;
    logic lastBeat;

    // Reads keep one beat outstanding: the strobe drops until its data returns.
    always_comb begin
        lastBeat = single | (beat == 2'd3);
        m0_write = run & isWrite;
        m0_read  = run & ~isWrite & ~pending;
        capture  = run & ~isWrite & pending & m0_readDataValid;
        done     = ((m0_write & ~m0_waitRequest) | capture) & lastBeat;
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            beat    <= 2'd0;
            pending <= 1'b0;
        end else begin
            pending <= (m0_read & ~m0_waitRequest) | (pending & ~capture);
            if ((m0_write & ~m0_waitRequest) | capture) beat <= lastBeat ? 2'd0 : beat + 2'd1;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-back cache sequencer with dirty writeback, refill and uncached bypass
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter  int SIZE  = 8*1024,
    localparam int IDX_W = $clog2(SIZE/16),
    localparam int TAG_W = 28-IDX_W
) (
    input  logic               clk,
    input  logic               rest,
    input  logic [31:0]        s0_address,
    input  logic [3:0]         s0_byteEnable,
    input  logic               s0_read,
    input  logic               s0_write,
    input  logic [31:0]        s0_writeData,
    output logic [31:0]        s0_readData,
    output logic               s0_waitRequest,
    output logic               s0_readDataValid,
    output logic [31:0]        m0_address,
    output logic [3:0]         m0_byteEnable,
    output logic               m0_read,
    output logic               m0_write,
    output logic [31:0]        m0_writeData,
    input  logic [31:0]        m0_readData,
    input  logic               m0_waitRequest,
    input  logic               m0_readDataValid,
    input  logic               isIOAddrBlock,
    input  logic               isEnableCache,
    output logic [IDX_W-1:0]   dataRam_readAddress,
    output logic [IDX_W-1:0]   dataRam_writeAddress,
    input  logic [LINE_W-1:0]  dataRam_readData,
    output logic [LINE_W-1:0]  dataRam_writeData,
    output logic               dataRam_writeEnable,
    output logic [15:0]        dataRam_writeByteEnable,
    output logic [IDX_W-1:0]   tagRam_readAddress,
    output logic [IDX_W-1:0]   tagRam_writeAddress,
    input  logic [TAG_W+1:0]   tagRam_readData,
    output logic [TAG_W+1:0]   tagRam_writeData,
    output logic               tagRam_writeEnable
);

    cacheState         state, nextState;
    logic [IDX_W-1:0]  initCnt;
    logic [31:0]       latAddr, latData;
    logic [3:0]        latBe;
    logic              latRead;
    logic [LINE_W-1:0] lineBuf;
    logic [TAG_W-1:0]  victimTag;
    logic [1:0]        beat;
    logic              capture, done, accept, hit, writeHit;

    wire [TAG_W-1:0] latTag  = latAddr[31:IDX_W+LINE_OFS];
    wire [IDX_W-1:0] latIdx  = latAddr[IDX_W+LINE_OFS-1:LINE_OFS];
    wire [1:0]       latWord = latAddr[3:2];
    wire             tagValid = tagRam_readData[TAG_W+1];
    wire             tagDirty = tagRam_readData[TAG_W];
    wire [TAG_W-1:0] tagTag   = tagRam_readData[TAG_W-1:0];

    cache_ctrl_bus_seq busSeq (
        .clk              (clk),
        .rest             (rest),
        .run              (state == WB || state == RF || state == UNC),
        .isWrite          (state == WB || (state == UNC && !latRead)),
        .single           (state == UNC),
        .m0_waitRequest   (m0_waitRequest),
        .m0_readDataValid (m0_readDataValid),
        .beat             (beat),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .capture          (capture),
        .done             (done)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= INIT;
        else       state <= nextState;
    end

    always_comb begin
        accept   = (state == IDLE) && (s0_read || s0_write);
        hit      = tagValid && (tagTag == latTag);
        writeHit = (state == LOOKUP) && hit && !latRead;
        case (state)
            INIT:    nextState = &initCnt ? IDLE : INIT;
            IDLE:    nextState = !accept ? IDLE : (isIOAddrBlock || !isEnableCache) ? UNC : LOOKUP;
            LOOKUP:  nextState = hit ? IDLE : (tagValid && tagDirty) ? WB : RF;
            WB:      nextState = done ? RF : WB;
            RF:      nextState = done ? FILL : RF;
            FILL:    nextState = IDLE;
            UNC:     nextState = done ? IDLE : UNC;
            default: nextState = INIT;
        endcase
    end

    // Tag clearing is gated by rest so nothing is written while reset is held.
    always_comb begin
        s0_waitRequest          = state != IDLE;
        dataRam_readAddress     = (state == IDLE) ? s0_address[IDX_W+LINE_OFS-1:LINE_OFS] : latIdx;
        tagRam_readAddress      = dataRam_readAddress;
        dataRam_writeAddress    = latIdx;
        tagRam_writeAddress     = (state == INIT) ? initCnt : latIdx;
        dataRam_writeEnable     = writeHit || state == FILL;
        dataRam_writeByteEnable = (state == FILL) ? 16'hFFFF : 16'(latBe) << {latWord, 2'b00};
        dataRam_writeData       = (state == FILL) ? mergeWord(lineBuf, latWord, latRead ? 4'h0 : latBe, latData)
                                                  : {4{latData}};
        tagRam_writeEnable      = (state == INIT && rest) || writeHit || state == FILL;
        tagRam_writeData        = (state == INIT) ? '0 : {1'b1, writeHit || !latRead, latTag};
        m0_address              = (state == UNC) ? latAddr
                                                 : {(state == WB) ? victimTag : latTag, latIdx, beat, 2'b00};
        m0_byteEnable           = (state == UNC) ? latBe : 4'hF;
        m0_writeData            = (state == UNC) ? latData : lineBuf[{beat, 5'd0} +: 32];
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            initCnt          <= '0;
            latAddr          <= '0;
            latData          <= '0;
            latBe            <= '0;
            latRead          <= 1'b0;
            lineBuf          <= '0;
            victimTag        <= '0;
            s0_readData      <= '0;
            s0_readDataValid <= 1'b0;
        end else begin
            s0_readDataValid <= 1'b0;
            if (state == INIT) initCnt <= initCnt + IDX_W'(1);
            if (accept) begin
                latAddr <= s0_address;
                latData <= s0_writeData;
                latBe   <= s0_byteEnable;
                latRead <= s0_read;
            end
            if (state == LOOKUP) begin
                lineBuf   <= dataRam_readData;
                victimTag <= tagTag;
                if (hit && latRead) begin
                    s0_readData      <= dataRam_readData[{latWord, 5'd0} +: 32];
                    s0_readDataValid <= 1'b1;
                end
            end
            if (state == RF && capture) lineBuf[{beat, 5'd0} +: 32] <= m0_readData;
            if (state == FILL && latRead) begin
                s0_readData      <= lineBuf[{latWord, 5'd0} +: 32];
                s0_readDataValid <= 1'b1;
            end
            if (state == UNC && capture) begin
                s0_readData      <= m0_readData;
                s0_readDataValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed scenarios for cache_ctrl with behavioural RAMs and a stalling bus slave
module tb_cache_ctrl;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } busTxn;

    logic         clk = 1'b0;
    logic         rest = 1'b0;
    logic [31:0]  s0_address = '0, s0_writeData = '0, s0_readData;
    logic [3:0]   s0_byteEnable = '0;
    logic         s0_read = 1'b0, s0_write = 1'b0, s0_waitRequest, s0_readDataValid;
    logic [31:0]  m0_address, m0_writeData, m0_readData = '0;
    logic [3:0]   m0_byteEnable;
    logic         m0_read, m0_write, m0_waitRequest, m0_readDataValid = 1'b0;
    logic         isIOAddrBlock = 1'b0, isEnableCache = 1'b1;
    logic [8:0]   dataRam_readAddress, dataRam_writeAddress, tagRam_readAddress, tagRam_writeAddress;
    logic [127:0] dataRam_readData = '0, dataRam_writeData;
    logic         dataRam_writeEnable, tagRam_writeEnable;
    logic [15:0]  dataRam_writeByteEnable;
    logic [20:0]  tagRam_readData = '0, tagRam_writeData;

    logic [127:0] dataMem [512];
    logic [20:0]  tagMem  [512];
    int           dataWrites = 0, tagWrites = 0;
    busTxn        busLog [$];
    int           stallCfg = 0, waitCnt = 0;
    int           checks = 0, failures = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writeData(s0_writeData), .s0_readData(s0_readData), .s0_waitRequest(s0_waitRequest),
        .s0_readDataValid(s0_readDataValid),
        .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writeData(m0_writeData), .m0_readData(m0_readData), .m0_waitRequest(m0_waitRequest),
        .m0_readDataValid(m0_readDataValid),
        .isIOAddrBlock(isIOAddrBlock), .isEnableCache(isEnableCache),
        .dataRam_readAddress(dataRam_readAddress), .dataRam_writeAddress(dataRam_writeAddress),
        .dataRam_readData(dataRam_readData), .dataRam_writeData(dataRam_writeData),
        .dataRam_writeEnable(dataRam_writeEnable), .dataRam_writeByteEnable(dataRam_writeByteEnable),
        .tagRam_readAddress(tagRam_readAddress), .tagRam_writeAddress(tagRam_writeAddress),
        .tagRam_readData(tagRam_readData), .tagRam_writeData(tagRam_writeData),
        .tagRam_writeEnable(tagRam_writeEnable)
    );

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) begin
        dataRam_readData <= dataMem[dataRam_readAddress];
        tagRam_readData  <= tagMem[tagRam_readAddress];
        if (dataRam_writeEnable) begin
            for (int b = 0; b < 16; b++)
                if (dataRam_writeByteEnable[b]) dataMem[dataRam_writeAddress][8*b +: 8] <= dataRam_writeData[8*b +: 8];
            dataWrites <= dataWrites + 1;
        end
        if (tagRam_writeEnable) begin
            tagMem[tagRam_writeAddress] <= tagRam_writeData;
            tagWrites <= tagWrites + 1;
        end
    end

    assign m0_waitRequest = (m0_read || m0_write) && (waitCnt < stallCfg);

    always @(posedge clk) begin
        m0_readDataValid <= 1'b0;
        if (m0_read || m0_write) begin
            if (waitCnt < stallCfg) waitCnt <= waitCnt + 1;
            else begin
                waitCnt <= 0;
                busLog.push_back({m0_write, m0_address, m0_writeData, m0_byteEnable});
                if (m0_read) begin
                    m0_readDataValid <= 1'b1;
                    m0_readData      <= memFn(m0_address);
                end
            end
        end
    end

    // One CPU request; lat = negedges from acceptance to the first IDLE cycle, busy = stalled negedges.
    task automatic cpuAccess(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, output logic [31:0] rdata,
                             output logic valid, output int lat, output int busy);
        int n;
        @(negedge clk);
        s0_read = rd; s0_write = !rd; s0_address = addr; s0_byteEnable = be; s0_writeData = wdata;
        n = 0;
        while (s0_waitRequest !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        s0_read = 1'b0; s0_write = 1'b0;
        lat = 0; busy = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (s0_waitRequest === 1'b0) break;
            busy++;
        end
        valid = s0_readDataValid;
        rdata = s0_readData;
        if (n >= 2000 || lat >= 2000) begin
            checks++; failures++;
            $display("FAIL timeout addr=%h accept_wait=%0d lat=%0d", addr, n, lat);
        end
    endtask

    task automatic test_reset;
        int n, bad, tw;
        for (int i = 0; i < 512; i++) begin tagMem[i] = '1; dataMem[i] = '0; end
        repeat (3) @(negedge clk);
        checks++; if (s0_waitRequest !== 1'b1) begin failures++; $display("FAIL rst_wait got %b want 1", s0_waitRequest); end
        checks++; if (s0_readDataValid !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", s0_readDataValid); end
        checks++; if ({m0_read, m0_write} !== 2'b00) begin failures++; $display("FAIL rst_m0 got %b want 00", {m0_read, m0_write}); end
        checks++; if (s0_readData !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h want 0", s0_readData); end
        checks++; if ({tagRam_writeEnable, dataRam_writeEnable} !== 2'b00) begin failures++; $display("FAIL rst_we got %b want 00", {tagRam_writeEnable, dataRam_writeEnable}); end
        tw = tagWrites;
        rest = 1'b1;
        n = 0;
        while (s0_waitRequest === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 512) begin failures++; $display("FAIL init_cycles got %0d want 512", n); end
        checks++; if (tagWrites - tw != 512) begin failures++; $display("FAIL init_tag_writes got %0d want 512", tagWrites - tw); end
        bad = 0;
        for (int i = 0; i < 512; i++) if (tagMem[i] !== 21'h0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL init_tag_rows nonzero=%0d want 0", bad); end
        checks++; if (busLog.size() != 0) begin failures++; $display("FAIL init_m0 got %0d txns want 0", busLog.size()); end
    endtask

    task automatic test_cold_read;
        logic [31:0] rd; logic v; int lat, busy, base;
        base = busLog.size();
        cpuAccess(1'b1, 32'h1000, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if (busLog.size() - base != 4) begin failures++; $display("FAIL cold_txns got %0d want 4", busLog.size() - base); end
        for (int i = 0; i < 4 && base + i < busLog.size(); i++) begin
            checks++;
            if ({busLog[base+i].wr, busLog[base+i].addr} !== {1'b0, 32'h1000 + 32'(4*i)}) begin
                failures++; $display("FAIL cold_beat%0d got wr=%b addr=%h want read %h", i, busLog[base+i].wr, busLog[base+i].addr, 32'h1000 + 32'(4*i));
            end
        end
        checks++; if ({v, rd} !== {1'b1, memFn(32'h1000)}) begin failures++; $display("FAIL cold_data got %b/%h want 1/%h", v, rd, memFn(32'h1000)); end
        checks++; if (tagMem[9'h100] !== 21'h100000) begin failures++; $display("FAIL cold_tag got %h want 100000", tagMem[9'h100]); end
        base = busLog.size();
        cpuAccess(1'b1, 32'h1000, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if (lat != 2) begin failures++; $display("FAIL hit_latency got %0d want 2", lat); end
        checks++; if ({v, rd} !== {1'b1, memFn(32'h1000)}) begin failures++; $display("FAIL hit_data got %b/%h want 1/%h", v, rd, memFn(32'h1000)); end
        cpuAccess(1'b1, 32'h100C, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if ({v, rd} !== {1'b1, memFn(32'h100C)}) begin failures++; $display("FAIL hit_word3 got %b/%h want 1/%h", v, rd, memFn(32'h100C)); end
        checks++; if (busLog.size() != base) begin failures++; $display("FAIL hit_m0 got %0d txns want 0", busLog.size() - base); end
    endtask

    task automatic test_write_hit;
        logic [31:0] rd, exp; logic v; int lat, busy, base;
        base = busLog.size();
        exp = (memFn(32'h1004) & 32'hFFFF_0000) | 32'h0000_CCDD;
        cpuAccess(1'b0, 32'h1004, 4'b0011, 32'hAABB_CCDD, rd, v, lat, busy);
        checks++; if (busy != 1) begin failures++; $display("FAIL whit_busy got %0d want 1", busy); end
        checks++; if (tagMem[9'h100] !== 21'h180000) begin failures++; $display("FAIL whit_tag got %h want 180000", tagMem[9'h100]); end
        cpuAccess(1'b1, 32'h1004, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if ({v, rd} !== {1'b1, exp}) begin failures++; $display("FAIL whit_merge got %b/%h want 1/%h", v, rd, exp); end
        checks++; if (busLog.size() != base) begin failures++; $display("FAIL whit_m0 got %0d txns want 0", busLog.size() - base); end
    endtask

    task automatic test_writeback;
        logic [31:0] rd, line [4]; logic v; int lat, busy, base;
        line[0] = memFn(32'h1000);
        line[1] = (memFn(32'h1004) & 32'hFFFF_0000) | 32'h0000_CCDD;
        line[2] = memFn(32'h1008);
        line[3] = memFn(32'h100C);
        stallCfg = 2;
        base = busLog.size();
        cpuAccess(1'b1, 32'h3000, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if (busLog.size() - base != 8) begin failures++; $display("FAIL wb_txns got %0d want 8", busLog.size() - base); end
        for (int i = 0; i < 4 && base + 4 + i < busLog.size(); i++) begin
            checks++;
            if (busLog[base+i] !== {1'b1, 32'h1000 + 32'(4*i), line[i], 4'hF}) begin
                failures++; $display("FAIL wb_beat%0d got %h want %h", i, busLog[base+i], {1'b1, 32'h1000 + 32'(4*i), line[i], 4'hF});
            end
            checks++;
            if ({busLog[base+4+i].wr, busLog[base+4+i].addr} !== {1'b0, 32'h3000 + 32'(4*i)}) begin
                failures++; $display("FAIL rf_beat%0d got wr=%b addr=%h want read %h", i, busLog[base+4+i].wr, busLog[base+4+i].addr, 32'h3000 + 32'(4*i));
            end
        end
        checks++; if ({v, rd} !== {1'b1, memFn(32'h3000)}) begin failures++; $display("FAIL wb_data got %b/%h want 1/%h", v, rd, memFn(32'h3000)); end
        checks++; if (tagMem[9'h100] !== 21'h100001) begin failures++; $display("FAIL wb_tag got %h want 100001", tagMem[9'h100]); end
        stallCfg = 0;
    endtask

    task automatic test_uncached;
        logic [31:0] rd; logic v; int lat, busy, base, dw, tw;
        stallCfg = 5;
        base = busLog.size(); dw = dataWrites; tw = tagWrites;
        isIOAddrBlock = 1'b1;
        cpuAccess(1'b0, 32'hF000_0000, 4'b0101, 32'h1234_5678, rd, v, lat, busy);
        isIOAddrBlock = 1'b0;
        checks++; if (busLog.size() - base != 1) begin failures++; $display("FAIL io_txns got %0d want 1", busLog.size() - base); end
        if (busLog.size() > base) begin
            checks++;
            if (busLog[base] !== {1'b1, 32'hF000_0000, 32'h1234_5678, 4'b0101}) begin
                failures++; $display("FAIL io_txn got %h want %h", busLog[base], {1'b1, 32'hF000_0000, 32'h1234_5678, 4'b0101});
            end
        end
        checks++; if (busy != 6) begin failures++; $display("FAIL io_stall got %0d want 6", busy); end
        checks++; if ((dataWrites - dw) + (tagWrites - tw) != 0) begin failures++; $display("FAIL io_ram_writes got %0d want 0", (dataWrites - dw) + (tagWrites - tw)); end
        stallCfg = 0;
        base = busLog.size();
        isEnableCache = 1'b0;
        cpuAccess(1'b1, 32'h2000, 4'hF, 32'h0, rd, v, lat, busy);
        isEnableCache = 1'b1;
        checks++; if (lat != 3) begin failures++; $display("FAIL unc_latency got %0d want 3", lat); end
        checks++; if ({v, rd} !== {1'b1, memFn(32'h2000)}) begin failures++; $display("FAIL unc_data got %b/%h want 1/%h", v, rd, memFn(32'h2000)); end
        checks++; if (busLog.size() - base != 1) begin failures++; $display("FAIL unc_txns got %0d want 1", busLog.size() - base); end
        checks++; if (tagWrites != tw) begin failures++; $display("FAIL unc_tag got %0d writes want 0", tagWrites - tw); end
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] rd; logic v; int lat, busy, base, n;
        base = busLog.size();
        @(negedge clk);
        s0_read = 1'b1; s0_address = 32'h5000;
        @(posedge clk);
        #1;
        s0_read = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m0_read === 1'b1 && m0_address === 32'h5008) && n < 100);
        checks++; if (n >= 100) begin failures++; $display("FAIL rf_beat2_reached got %0d cycles want <100", n); end
        rest = 1'b0;
        #1;
        checks++; if ({m0_read, s0_waitRequest} !== 2'b01) begin failures++; $display("FAIL rst_mid_rf got read=%b wait=%b want 0/1", m0_read, s0_waitRequest); end
        checks++; if (busLog.size() - base != 2) begin failures++; $display("FAIL rst_mid_txns got %0d want 2", busLog.size() - base); end
        repeat (3) @(negedge clk);
        rest = 1'b1;
        n = 0;
        while (s0_waitRequest !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 512) begin failures++; $display("FAIL reinit_cycles got %0d want 512", n); end
        base = busLog.size();
        cpuAccess(1'b1, 32'h5000, 4'hF, 32'h0, rd, v, lat, busy);
        checks++; if (busLog.size() - base != 4) begin failures++; $display("FAIL reread_txns got %0d want 4", busLog.size() - base); end
        if (busLog.size() > base) begin
            checks++;
            if ({busLog[base].wr, busLog[base].addr} !== {1'b0, 32'h5000}) begin
                failures++; $display("FAIL reread_first got wr=%b addr=%h want read 5000", busLog[base].wr, busLog[base].addr);
            end
        end
        checks++; if ({v, rd} !== {1'b1, memFn(32'h5000)}) begin failures++; $display("FAIL reread_data got %b/%h want 1/%h", v, rd, memFn(32'h5000)); end
        checks++; if (tagMem[9'h100] !== 21'h100002) begin failures++; $display("FAIL reread_tag got %h want 100002", tagMem[9'h100]); end
    endtask

    initial begin
        test_reset;
        test_cold_read;
        test_write_hit;
        test_writeback;
        test_uncached;
        test_reset_mid_refill;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
